// File: rtl/core_wb_queue.sv
// Writeback queue between execute and the GP register file: two in-order enqueue
// lanes, up to two retirements per cycle, plus a pending-write query for hazard checks.
package core_wb_pkg;
    typedef logic [4:0]  reg_num;
    typedef logic [31:0] word;

    localparam reg_num R0 = '0;

    typedef struct packed {
        logic   ready;
        reg_num rd;
        word    value;
    } wb_line;
endpackage

module core_wb_queue
    import core_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_a_valid,
    input  reg_num in_a_rd,
    input  word    in_a_value,
    output logic   in_a_ready,
    input  logic   in_b_valid,
    input  reg_num in_b_rd,
    input  word    in_b_value,
    output logic   in_b_ready,
    input  logic   stall,
    input  logic   flush,
    output wb_line wr_a,
    output wb_line wr_b,
    input  reg_num pend_q,
    output logic   pend,
    output logic   busy
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Advance a pointer by k (k <= 2 < DEPTH+...), wrapping modulo DEPTH.
    function automatic ptr_t ptr_add(input ptr_t p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return s[PW-1:0];
    endfunction

    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    cnt_t   count_q, count_d;

    reg_num rd_mem_q  [DEPTH];
    word    val_mem_q [DEPTH];

    logic       store_a, store_b;
    logic       ret_a, ret_b;
    logic [1:0] enq_num, deq_num;
    ptr_t       head1, tail1, b_slot;

    // Readiness looks only at the registered count, never at this cycle's retirement.
    assign in_a_ready = !flush && (count_q <= cnt_t'(DEPTH - 1));
    assign in_b_ready = !flush && (count_q <= cnt_t'(DEPTH - 2));

    assign store_a = in_a_valid && in_a_ready && (in_a_rd != R0);
    assign store_b = in_b_valid && in_b_ready && (in_b_rd != R0);
    assign enq_num = {1'b0, store_a} + {1'b0, store_b};

    assign ret_a   = !stall && !flush && (count_q != '0);
    assign ret_b   = ret_a && (count_q >= cnt_t'(2));
    assign deq_num = {1'b0, ret_a} + {1'b0, ret_b};

    assign head1  = ptr_add(head_q, 1);
    assign tail1  = ptr_add(tail_q, 1);
    assign b_slot = store_a ? tail1 : tail_q;

    assign wr_a = '{ready: ret_a, rd: rd_mem_q[head_q], value: val_mem_q[head_q]};
    assign wr_b = '{ready: ret_b, rd: rd_mem_q[head1],  value: val_mem_q[head1]};

    assign busy = (count_q != '0);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        head_d  = ptr_add(head_q, 32'(deq_num));
        tail_d  = ptr_add(tail_q, 32'(enq_num));
        count_d = count_q + cnt_t'(enq_num) - cnt_t'(deq_num);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        pend = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < 32'(count_q) && rd_mem_q[ptr_add(head_q, i)] == pend_q) pend = 1'b1;
        end
        if (pend_q == R0) pend = 1'b0;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry storage is not reset; count gates every read that matters.
    always_ff @(posedge clk) begin
        if (store_a) begin
            rd_mem_q[tail_q]  <= in_a_rd;
            val_mem_q[tail_q] <= in_a_value;
        end
        if (store_b) begin
            rd_mem_q[b_slot]  <= in_b_rd;
            val_mem_q[b_slot] <= in_b_value;
        end
    end
endmodule

// File: tb/tb_core_wb_queue.sv
// Self-checking bench for core_wb_queue: a scoreboard queue models the FIFO and
// every retirement, readiness, busy and pend output is compared against it each cycle.
module tb_core_wb_queue;
    import core_wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        reg_num rd;
        word    value;
    } ent_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   in_a_valid, in_b_valid;
    reg_num in_a_rd, in_b_rd;
    word    in_a_value, in_b_value;
    logic   in_a_ready, in_b_ready;
    logic   stall, flush;
    wb_line wr_a, wr_b;
    reg_num pend_q;
    logic   pend, busy;

    int   errors = 0;
    int   checks = 0;
    ent_t sb[$];

    core_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_a_valid (in_a_valid),
        .in_a_rd    (in_a_rd),
        .in_a_value (in_a_value),
        .in_a_ready (in_a_ready),
        .in_b_valid (in_b_valid),
        .in_b_rd    (in_b_rd),
        .in_b_value (in_b_value),
        .in_b_ready (in_b_ready),
        .stall      (stall),
        .flush      (flush),
        .wr_a       (wr_a),
        .wr_b       (wr_b),
        .pend_q     (pend_q),
        .pend       (pend),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic model_pend(input reg_num q);
        logic p;
        p = 1'b0;
        foreach (sb[i]) if (sb[i].rd == q) p = 1'b1;
        return p && (q != R0);
    endfunction

    // One clock: drive at the falling edge, compare against the model, then update it.
    task automatic cycle(input logic av, input reg_num ard, input word aval,
                         input logic bv, input reg_num brd, input word bval,
                         input logic st, input logic fl, input reg_num pq);
        int   cnt, nd;
        logic exp_ar, exp_br;
        @(negedge clk);
        in_a_valid = av; in_a_rd = ard; in_a_value = aval;
        in_b_valid = bv; in_b_rd = brd; in_b_value = bval;
        stall = st; flush = fl; pend_q = pq;
        #1;
        cnt    = sb.size();
        exp_ar = !fl && (cnt <= DEPTH - 1);
        exp_br = !fl && (cnt <= DEPTH - 2);
        check("in_a_ready", 64'(in_a_ready), 64'(exp_ar));
        check("in_b_ready", 64'(in_b_ready), 64'(exp_br));
        check("busy", 64'(busy), 64'(cnt != 0));
        check("pend", 64'(pend), 64'(model_pend(pq)));
        nd = (st || fl) ? 0 : ((cnt >= 2) ? 2 : cnt);
        check("wr_a.ready", 64'(wr_a.ready), 64'(nd >= 1));
        check("wr_b.ready", 64'(wr_b.ready), 64'(nd >= 2));
        if (nd >= 1) begin
            check("wr_a.rd", 64'(wr_a.rd), 64'(sb[0].rd));
            check("wr_a.value", 64'(wr_a.value), 64'(sb[0].value));
        end
        if (nd >= 2) begin
            check("wr_b.rd", 64'(wr_b.rd), 64'(sb[1].rd));
            check("wr_b.value", 64'(wr_b.value), 64'(sb[1].value));
        end
        for (int i = 0; i < nd; i++) void'(sb.pop_front());
        if (fl) sb.delete();
        if (av && exp_ar && ard != R0) sb.push_back('{rd: ard, value: aval});
        if (bv && exp_br && brd != R0) sb.push_back('{rd: brd, value: bval});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_a_valid = 0; in_a_rd = 0; in_a_value = 0;
        in_b_valid = 0; in_b_rd = 0; in_b_value = 0;
        stall = 0; flush = 0; pend_q = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, then a single write: visible next cycle, busy clears after.
        idle(1);
        cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 5);
        check("single_wr_a_visible", 64'(sb.size()), 64'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 5);
        idle(1);

        // Stall fill: third pair must be refused, then in-order drain.
        cycle(1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1);
        cycle(1, 3, 32'h33, 1, 4, 32'h44, 1, 0, 3);
        cycle(1, 5, 32'h55, 1, 6, 32'h66, 1, 0, 4);
        check("stall_fill_count", 64'(sb.size()), 64'd4);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 4);
        idle(1);

        // Count = DEPTH-1: only lane A ready.
        cycle(1, 8, 32'h80, 1, 9, 32'h90, 1, 0, 0);
        cycle(1, 10, 32'hA0, 0, 0, 0, 1, 0, 0);
        cycle(1, 11, 32'hB0, 1, 12, 32'hC0, 1, 0, 11);
        idle(3);

        // Same-rd pair retires together with the younger value on wr_b.
        cycle(1, 7, 32'd1, 1, 7, 32'd2, 0, 0, 7);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 7);
        idle(1);

        // R0 results handshake but are never stored.
        cycle(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 32'h1, 1, 13, 32'hD0, 0, 0, 13);
        idle(2);

        // Flush with three stored entries and lane A valid.
        cycle(1, 20, 32'h200, 1, 21, 32'h210, 1, 0, 0);
        cycle(1, 22, 32'h220, 0, 0, 0, 1, 0, 21);
        cycle(1, 23, 32'h230, 0, 0, 0, 1, 1, 22);
        @(negedge clk);
        in_a_valid = 0; stall = 0; flush = 0;
        for (int r = 1; r < 32; r++) begin
            pend_q = reg_num'(r);
            #1;
            check("flush_pend", 64'(pend), 64'd0);
        end
        check("flush_busy", 64'(busy), 64'd0);
        idle(2);

        // Random traffic exercises wrap-around, mixed stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), reg_num'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1), reg_num'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 39) == 0),
                  reg_num'($urandom_range(0, 15)));
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // Async reset mid-stream with two entries held.
        cycle(1, 9, 32'h900, 1, 10, 32'hA00, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 9);
        @(negedge clk);
        stall = 0; pend_q = 10;
        #1;
        check("pre_rst_wr_a.ready", 64'(wr_a.ready), 64'd1);
        check("pre_rst_pend", 64'(pend), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wr_a.ready", 64'(wr_a.ready), 64'd0);
        check("rst_wr_b.ready", 64'(wr_b.ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pend", 64'(pend), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_wb_queue.md
# core_wb_queue

Writeback queue that drives the two register-file write ports (`wr_a`, `wr_b`, type `wb_line`). Functional units hand results in on two valid/ready input lanes. Results are buffered in an in-order FIFO and retired up to two per cycle toward the register file. The block sits between execute and the GP register file and also answers a pending-write query for hazard checks.

## Interface
- `DEPTH`, default 4: FIFO entries; must be ≥2.
- `clk`  in  1: core clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous and active-high; clears all state.
- `in_a_valid`  in  1: lane A result valid; lane A is older than lane B in the same cycle.
- `in_a_rd`  in  `reg_num`: lane A destination.
- `in_a_value`  in  `word`: lane A data.
- `in_a_ready`  out  1: lane A may be accepted.
- `in_b_valid`, `in_b_rd`, `in_b_value`, `in_b_ready`: lane B, same meanings.
- `stall`  in  1: hold; no retirement this cycle.
- `flush`  in  1: discard all stored entries and this cycle's inputs.
- `wr_a`, `wr_b`  out  `wb_line` (`ready`, `rd`, `value`): register-file write ports; `wr_b` is the younger of the two.
- `pend_q`  in  `reg_num`: register to query.
- `pend`  out  1: a stored entry targets `pend_q`.
- `busy`  out  1: FIFO non-empty.

## Operation
- Storage is a circular FIFO of `DEPTH` entries, each holding {`rd`, `value`}.
- State consists of the head pointer, tail pointer and count (width `$clog2(DEPTH+1)`). Pointers wrap modulo `DEPTH`.
- Handshake readiness:
  - `in_a_ready` = !flush && count ≤ DEPTH-1.
  - `in_b_ready` = !flush && count ≤ DEPTH-2.
  - Both are computed from the registered count only, with no path from this cycle's retirement. This is conservative.
- A lane transfers when valid && ready.
- Enqueue order:
  - If both lanes transfer, A is written at tail and B at tail+1.
  - If only one lane transfers, it is written at tail.
- Results with `rd` == R0 complete the handshake but are not stored.
- Retirement (combinational outputs from stored entries):
  - If !stall && !flush and count ≥1: `wr_a` = head entry with `ready`=1.
  - If additionally count ≥2: `wr_b` = head+1 entry with `ready`=1.
  - Otherwise the corresponding `ready` is 0; `rd`/`value` are don't-care but driven from the entry.
  - The register file always accepts, so every presented entry is popped at the same edge.
- Same-`rd` pair: both entries are presented. The register file gives `wr_b` (younger) priority, which yields correct final state.
- Count update: next = count + enq − deq, where enq ∈ {0,1,2} and deq ∈ {0,1,2}. Enqueue and dequeue in the same cycle are legal.
- `flush` sets count and pointers to 0 at the edge. Flush overrides stall and all inputs.
- `pend` = OR over stored entries (index < count from head) of (`rd` == `pend_q`). It is forced to 0 when `pend_q` == R0.
- `busy` = count != 0.

## Timing
- Reset values: count 0, pointers 0.
  - `wr_a.ready` = `wr_b.ready` = 0.
  - `in_a_ready` = `in_b_ready` = 1 when `flush` = 0.
  - `busy` = 0, `pend` = 0.
- Reset mid-operation discards all entries immediately. No writes are issued afterward.
- Latency for a result accepted at edge N into an empty, unstalled queue:
  - Visible on `wr_a` during cycle N+1.
  - Committed to the register file at edge N+1.
- Throughput is 2 results/cycle sustained. The queue reaches full only while `stall` is held.
- Full (count = DEPTH): both input readys are 0.
- count = DEPTH-1: only `in_a_ready` is 1.
- Wrap-around must preserve order: entries at DEPTH-1 and 0 retire as `wr_a` then `wr_b`.
- `pend` reflects registered contents. An entry being retired in the current cycle still reports pending.

## Test plan
- **Single write:** reset, one A transfer rd=5 value=0x1234 → `wr_a` = {1, 5, 0x1234} next cycle, `busy` back to 0 one cycle later.
- **Stall fill:** stall=1, feed pairs (rd 1..4) with DEPTH=4 → readys drop after 2 pairs; release stall → `wr_a`/`wr_b` = rd1/rd2, then rd3/rd4, in order.
- **Same-rd pair:** A rd=7 value=1, B rd=7 value=2 same cycle → both retire together, `wr_b.value` = 2.
- **R0 filtering:** A rd=R0 value=0xFFFF → handshake completes, no `wr_a.ready`, `busy` stays 0.
- **Flush:** 3 entries held under stall, assert flush with A valid → no writes, count 0, A not accepted, `pend` = 0 for all queried rd.
- **Reset and pend:** async `rst` mid-stream with 2 entries → `wr_*.ready` = 0 immediately. Before reset, `pend_q` = held rd → `pend` = 1.
